// File: rtl/topk_collector.sv
// Streaming top-K collector: keeps the K nearest unique vertices sorted by
// squared distance and presents them in parallel once the search reports done.
module topk_collector #(
  parameter int K          = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DIST_WIDTH = 32
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             start_in,
  input  logic [ADDR_WIDTH-1:0]            cand_addr_in,
  input  logic [DIST_WIDTH-1:0]            cand_dist_in,
  input  logic                             cand_valid_in,
  output logic                             ready_out,
  input  logic                             done_in,
  output logic [K-1:0][ADDR_WIDTH-1:0]     top_k_out,
  output logic [K-1:0][DIST_WIDTH-1:0]     top_k_dist_out,
  output logic [$clog2(K+1)-1:0]           count_out,
  output logic                             valid_out,
  output logic                             busy_out
);
  localparam int CW = $clog2(K+1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                        r_state, w_next;
  logic [K-1:0][ADDR_WIDTH-1:0]  r_addr;
  logic [K-1:0][DIST_WIDTH-1:0]  r_dist;
  logic [CW-1:0]                 r_count, w_pos;
  logic                          r_pend, r_done_lat, r_valid;
  logic [ADDR_WIDTH-1:0]         r_pend_addr;
  logic [DIST_WIDTH-1:0]         r_pend_dist;
  logic                          w_ready, w_hs, w_dup, w_ins, w_done_req;

  // Once done is latched no further candidates are taken; only the pending one drains.
  assign w_ready    = (r_state == S_COLLECT) && !r_pend && !r_done_lat;
  assign w_hs       = cand_valid_in && w_ready;
  assign w_done_req = done_in || r_done_lat;

  // Insert position = occupied slots whose dist <= candidate (stable on ties).
  always_comb begin
    w_dup = 1'b0;
    w_pos = '0;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) < r_count) begin
        if (r_addr[i] == r_pend_addr) w_dup = 1'b1;
        if (r_dist[i] <= r_pend_dist) w_pos = w_pos + CW'(1);
      end
    end
  end

  assign w_ins = (r_state == S_COLLECT) && r_pend && !w_dup && (w_pos != CW'(K));

  always_comb begin
    w_next = r_state;
    if (start_in)
      w_next = S_COLLECT;
    else if (r_state == S_COLLECT && w_done_req && !r_pend && !w_hs)
      w_next = S_DONE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_dist <= '0;
      r_done_lat  <= 1'b0;
      r_count     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= (w_next == S_DONE) && (r_state != S_DONE);
      if (start_in) begin
        r_pend     <= 1'b0;
        r_done_lat <= 1'b0;
        r_count    <= '0;
      end else begin
        if (w_hs) begin
          r_pend      <= 1'b1;
          r_pend_addr <= cand_addr_in;
          r_pend_dist <= cand_dist_in;
        end else if (r_pend) begin
          r_pend <= 1'b0;
        end
        if (w_next == S_DONE)
          r_done_lat <= 1'b0;
        else if (r_state == S_COLLECT && done_in)
          r_done_lat <= 1'b1;
        if (w_ins && r_count != CW'(K))
          r_count <= r_count + CW'(1);
      end
    end
  end

  // Slots above the insert point shift down by one; the old last slot falls off.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_addr <= '0;
      r_dist <= '1;
    end else if (start_in) begin
      r_addr <= '0;
      r_dist <= '1;
    end else if (w_ins) begin
      for (int i = 0; i < K; i++) begin
        if (w_pos == CW'(i)) begin
          r_addr[i] <= r_pend_addr;
          r_dist[i] <= r_pend_dist;
        end else if (w_pos < CW'(i)) begin
          r_addr[i] <= r_addr[(i == 0) ? 0 : i-1];
          r_dist[i] <= r_dist[(i == 0) ? 0 : i-1];
        end
      end
    end
  end

  assign ready_out      = w_ready;
  assign busy_out       = (r_state == S_COLLECT);
  assign valid_out      = r_valid;
  assign count_out      = r_count;
  assign top_k_out      = r_addr;
  assign top_k_dist_out = r_dist;
endmodule

// File: tb/tb_topk_collector.sv
// Bench for topk_collector: directed and random queries against a queue-based
// sorted-list reference model.
module tb_topk_collector;
  localparam int K = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, c_valid = 1'b0, done = 1'b0;
  logic [31:0]       c_addr = '0, c_dist = '0;
  logic              ready, vout, busy;
  logic [K-1:0][31:0] topk, topd;
  logic [2:0]        cnt;

  int n_cmp = 0, n_bad = 0;
  int unsigned m_addr[$], m_dist[$];

  topk_collector #(.K(K), .ADDR_WIDTH(32), .DIST_WIDTH(32)) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .cand_addr_in(c_addr), .cand_dist_in(c_dist), .cand_valid_in(c_valid),
    .ready_out(ready), .done_in(done), .top_k_out(topk), .top_k_dist_out(topd),
    .count_out(cnt), .valid_out(vout), .busy_out(busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: sorted unique list, ties go after existing entries, capped at K.
  function automatic void m_push(input int unsigned a, input int unsigned d);
    int p = 0;
    foreach (m_addr[i]) if (m_addr[i] == a) return;
    foreach (m_dist[i]) if (m_dist[i] <= d) p++;
    if (p >= K) return;
    m_addr.insert(p, a);
    m_dist.insert(p, d);
    if (m_addr.size() > K) begin
      void'(m_addr.pop_back());
      void'(m_dist.pop_back());
    end
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag);
    logic [K-1:0][31:0] ea, ed;
    for (int i = 0; i < K; i++) begin
      ea[i] = (i < m_addr.size()) ? m_addr[i] : 32'h0;
      ed[i] = (i < m_dist.size()) ? m_dist[i] : 32'hFFFF_FFFF;
    end
    chk({tag, "/addr"},  256'(topk), 256'(ea));
    chk({tag, "/dist"},  256'(topd), 256'(ed));
    chk({tag, "/count"}, 256'(cnt),  256'(m_addr.size()));
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    m_addr.delete(); m_dist.delete();
  endtask

  task automatic send(input int unsigned a, input int unsigned d);
    int w = 0;
    @(negedge clk); c_valid = 1'b1; c_addr = a; c_dist = d;
    while (!ready && w < 8) begin @(negedge clk); w++; end
    if (!ready) chk("send/ready_timeout", 256'(ready), 256'(1));
    else begin
      @(posedge clk); m_push(a, d);
    end
    #1 c_valid = 1'b0;
  endtask

  // Pulses done (optionally with a coincident candidate) and checks the valid pulse.
  task automatic finish_q(input string tag, input int lat_exp, input logic with_c,
                          input int unsigned a, input int unsigned d);
    int w = 0, first = 0, hi = 0;
    @(negedge clk);
    while (!ready && w < 8) begin @(negedge clk); w++; end
    chk({tag, "/ready_before_done"}, 256'(ready), 256'(1));
    done = 1'b1;
    if (with_c) begin c_valid = 1'b1; c_addr = a; c_dist = d; end
    @(posedge clk);
    if (with_c && ready) m_push(a, d);
    #1 done = 1'b0; c_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (vout) begin
        if (first == 0) first = k;
        hi++;
      end
    end
    chk({tag, "/valid_latency"}, 256'(first), 256'(lat_exp));
    chk({tag, "/valid_width"},   256'(hi),    256'(1));
    chk({tag, "/busy"},          256'(busy),  256'(0));
    chk({tag, "/ready"},         256'(ready), 256'(0));
    chk_list(tag);
  endtask

  initial begin
    logic [K-1:0][31:0] ev;
    logic [11:0] pat, pexp;
    int unsigned ta[8], td[8];
    int idx;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst/ready", 256'(ready), 256'(0));
    chk("rst/valid", 256'(vout),  256'(0));
    chk("rst/busy",  256'(busy),  256'(0));
    chk_list("rst");
    rst_n = 1'b1;

    // Directed list
    do_start();
    chk("start/busy", 256'(busy), 256'(1));
    send(10, 50); send(11, 20); send(12, 70); send(13, 20); send(14, 5);
    finish_q("dir5", 1, 1'b0, 0, 0);
    ev[0] = 14; ev[1] = 11; ev[2] = 13; ev[3] = 10; ev[4] = 12;
    chk("dir5/const_addr", 256'(topk), 256'(ev));
    ev[0] = 5; ev[1] = 20; ev[2] = 20; ev[3] = 50; ev[4] = 70;
    chk("dir5/const_dist", 256'(topd), 256'(ev));

    // DONE holds: candidates and done ignored
    @(negedge clk); c_valid = 1'b1; c_addr = 99; c_dist = 0; done = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold/ready", 256'(ready), 256'(0));
    chk("hold/valid", 256'(vout),  256'(0));
    c_valid = 1'b0; done = 1'b0;
    chk_list("hold");

    // Tie with worst is dropped, better than worst evicts it
    do_start();
    send(10, 50); send(11, 20); send(12, 70); send(13, 20); send(14, 5);
    send(15, 70); send(16, 60);
    finish_q("evict", 1, 1'b0, 0, 0);
    chk("evict/slot4_addr", 256'(topk[4]), 256'(16));
    chk("evict/slot4_dist", 256'(topd[4]), 256'(60));

    // Duplicates
    do_start();
    send(10, 50); send(10, 50);
    repeat (2) @(negedge clk);
    chk("dup/count_pair", 256'(cnt), 256'(1));
    send(3, 7); send(10, 50);
    finish_q("dup", 1, 1'b0, 0, 0);

    // Continuous valid: one accept every two cycles
    do_start();
    for (int i = 0; i < 8; i++) begin ta[i] = 40 + i; td[i] = $urandom_range(30, 0); end
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      c_valid = 1'b1; c_addr = ta[idx]; c_dist = td[idx];
      pat[k] = ready;
      pexp[k] = (k % 2 == 0);
      if (ready) begin m_push(ta[idx], td[idx]); idx++; end
    end
    @(posedge clk); #1 c_valid = 1'b0;
    chk("tput/ready_pattern", 256'(pat), 256'(pexp));
    chk("tput/accepts", 256'(idx), 256'(6));
    finish_q("tput", 1, 1'b0, 0, 0);

    // done coincident with a handshake
    do_start();
    send(5, 9); send(6, 3);
    finish_q("coinc", 3, 1'b1, 20, 1);
    chk("coinc/slot0", 256'(topk[0]), 256'(20));

    // done with no candidates
    do_start();
    finish_q("empty", 1, 1'b0, 0, 0);

    // Random queries: small address/distance ranges force dups and ties
    for (int q = 0; q < 5; q++) begin
      do_start();
      for (int n = 0; n < 16; n++) begin
        if ($urandom_range(7, 0) == 0) send($urandom_range(11, 0), 32'hFFFF_FFFF);
        else send($urandom_range(11, 0), $urandom_range(20, 0));
        if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      finish_q($sformatf("rand%0d", q), 1, 1'b0, 0, 0);
    end

    // Async reset in the middle of an insert
    do_start();
    send(1, 4); send(2, 8);
    @(negedge clk); c_valid = 1'b1; c_addr = 3; c_dist = 1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    m_addr.delete(); m_dist.delete();
    chk("arst/ready", 256'(ready), 256'(0));
    chk("arst/busy",  256'(busy),  256'(0));
    chk("arst/valid", 256'(vout),  256'(0));
    chk_list("arst");
    c_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst/idle_ready", 256'(ready), 256'(0));

    // start mid-COLLECT clears the list
    do_start();
    send(7, 7); send(8, 2); send(9, 5);
    do_start();
    @(negedge clk);
    chk("restart/busy", 256'(busy), 256'(1));
    chk_list("restart");
    send(30, 30);
    finish_q("restart_fin", 1, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
